// File: rtl/mac_share_arbiter_pkg.sv
// Shared constants and types for the two-requester shared multiply-add unit.
// Pipeline latency and the round-robin pointer encoding live here.
package mac_arb_pkg;

    localparam int A_W_DEF = 27;
    localparam int B_W_DEF = 18;
    localparam int C_W_DEF = 48;
    localparam int P_W_DEF = 48;
    localparam int LATENCY = 3;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } ptr_e;

    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/mac_share_arbiter_if.sv
// Requester handshake, operand and result bundle for mac_share_arbiter.
// slave is the arbiter side, master the requester/consumer side.
interface mac_share_arbiter_if #(
    parameter int A_W = 27,
    parameter int B_W = 18,
    parameter int C_W = 48,
    parameter int P_W = 48
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic signed [A_W-1:0] a0;
    logic signed [B_W-1:0] b0;
    logic signed [C_W-1:0] c0;
    logic                  req1_valid;
    logic                  req1_ready;
    logic signed [A_W-1:0] a1;
    logic signed [B_W-1:0] b1;
    logic signed [C_W-1:0] c1;
    logic                  dout0_valid;
    logic                  dout1_valid;
    logic signed [P_W-1:0] dout0;
    logic signed [P_W-1:0] dout1;
    logic                  busy;

    modport slave (
        input  req0_valid, a0, b0, c0, req1_valid, a1, b1, c1,
        output req0_ready, req1_ready, dout0_valid, dout1_valid, dout0, dout1, busy
    );

    modport master (
        output req0_valid, a0, b0, c0, req1_valid, a1, b1, c1,
        input  req0_ready, req1_ready, dout0_valid, dout1_valid, dout0, dout1, busy
    );
endinterface

// File: rtl/mac_share_arbiter_pipe.sv
// Three-stage signed a*b+c pipeline carrying a valid bit and owner tag per stage.
// The third stage writes straight into the per-requester result registers.
module mac_pipe
    import mac_arb_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int C_W = C_W_DEF,
    parameter int P_W = P_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_tag,
    input  logic signed [A_W-1:0] in_a,
    input  logic signed [B_W-1:0] in_b,
    input  logic signed [C_W-1:0] in_c,
    output logic                  dout0_valid,
    output logic                  dout1_valid,
    output logic signed [P_W-1:0] dout0,
    output logic signed [P_W-1:0] dout1,
    output logic                  busy
);
    localparam int M_W   = A_W + B_W;
    // One guard bit keeps both sign-extension counts non-zero for any widths.
    localparam int SUM_W = max3(M_W, C_W, P_W) + 1;

    logic                  s1_valid_q, s1_valid_d, s1_tag_q, s1_tag_d;
    logic signed [A_W-1:0] s1_a_q, s1_a_d;
    logic signed [B_W-1:0] s1_b_q, s1_b_d;
    logic signed [C_W-1:0] s1_c_q, s1_c_d;
    logic                  s2_valid_q, s2_valid_d, s2_tag_q, s2_tag_d;
    logic        [M_W-1:0] s2_m_q, s2_m_d;
    logic signed [C_W-1:0] s2_c_q, s2_c_d;
    logic                  s3_valid_q, s3_valid_d, s3_tag_q, s3_tag_d;
    logic signed [P_W-1:0] dout0_q, dout0_d, dout1_q, dout1_d;
    logic        [M_W-1:0] prod;
    logic        [P_W-1:0] sum;

    // Low M_W bits of the product are identical for signed and unsigned operands.
    assign prod = {{(M_W-A_W){s1_a_q[A_W-1]}}, s1_a_q} * {{(M_W-B_W){s1_b_q[B_W-1]}}, s1_b_q};
    assign sum  = P_W'({{(SUM_W-M_W){s2_m_q[M_W-1]}}, s2_m_q}
                     + {{(SUM_W-C_W){s2_c_q[C_W-1]}}, s2_c_q});

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_c_d     = s1_c_q;
        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        s2_m_d     = s2_m_q;
        s2_c_d     = s2_c_q;
        s3_valid_d = s3_valid_q;
        s3_tag_d   = s3_tag_q;
        dout0_d    = dout0_q;
        dout1_d    = dout1_q;
        if (ce) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_tag_d = in_tag;
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_c_d   = in_c;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_tag_d = s1_tag_q;
                s2_m_d   = prod;
                s2_c_d   = s1_c_q;
            end
            s3_valid_d = s2_valid_q;
            s3_tag_d   = s2_tag_q;
            if (s2_valid_q && !s2_tag_q) dout0_d = sum;
            if (s2_valid_q &&  s2_tag_q) dout1_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= 1'b0;
            s2_m_q     <= '0;
            s2_c_q     <= '0;
            s3_valid_q <= 1'b0;
            s3_tag_q   <= 1'b0;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_c_q     <= s1_c_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_m_q     <= s2_m_d;
            s2_c_q     <= s2_c_d;
            s3_valid_q <= s3_valid_d;
            s3_tag_q   <= s3_tag_d;
            dout0_q    <= dout0_d;
            dout1_q    <= dout1_d;
        end
    end

    assign dout0_valid = ce & s3_valid_q & ~s3_tag_q;
    assign dout1_valid = ce & s3_valid_q &  s3_tag_q;
    assign dout0       = dout0_q;
    assign dout1       = dout1_q;
    assign busy        = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: rtl/mac_share_arbiter.sv
// Round-robin arbitration of two requesters onto one shared multiply-add pipeline.
// Only the grant logic and the tie-break pointer live here; arithmetic is in mac_pipe.
module mac_share_arbiter
    import mac_arb_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int C_W = C_W_DEF,
    parameter int P_W = P_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce,
    mac_share_arbiter_if.slave  bus
);
    ptr_e ptr_q, ptr_d;
    logic grant0, grant1, xfer0, xfer1;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | (ptr_q == PRI0));
        grant1 = bus.req1_valid & ~grant0;
    end

    assign bus.req0_ready = ce & rst_n & grant0;
    assign bus.req1_ready = ce & rst_n & grant1;
    assign xfer0          = bus.req0_valid & bus.req0_ready;
    assign xfer1          = bus.req1_valid & bus.req1_ready;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer0)      ptr_d = PRI1;
        else if (xfer1) ptr_d = PRI0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  ptr_q <= PRI0;
        else if (ce) ptr_q <= ptr_d;
    end

    mac_pipe #(
        .A_W (A_W),
        .B_W (B_W),
        .C_W (C_W),
        .P_W (P_W)
    ) u_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .ce          (ce),
        .in_valid    (xfer0 | xfer1),
        .in_tag      (xfer1),
        .in_a        (xfer1 ? bus.a1 : bus.a0),
        .in_b        (xfer1 ? bus.b1 : bus.b0),
        .in_c        (xfer1 ? bus.c1 : bus.c0),
        .dout0_valid (bus.dout0_valid),
        .dout1_valid (bus.dout1_valid),
        .dout0       (bus.dout0),
        .dout1       (bus.dout1),
        .busy        (bus.busy)
    );

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Scenario tasks for mac_share_arbiter backed by a per-port result scoreboard.
module tb_mac_share_arbiter;
    localparam int A_W = 27;
    localparam int B_W = 18;
    localparam int C_W = 48;
    localparam int P_W = 48;

    typedef struct {
        logic [P_W-1:0] val;
        int             due;
    } exp_t;

    logic clk;
    logic rst_n;
    logic ce;
    int   total;
    int   bad;
    int   ce_cnt;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    logic [P_W-1:0] last0;
    logic [P_W-1:0] last1;

    mac_share_arbiter_if #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .P_W(P_W)) bus ();

    mac_share_arbiter #(.A_W(A_W), .B_W(B_W), .C_W(C_W), .P_W(P_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [P_W-1:0] model(input logic signed [A_W-1:0] a,
                                             input logic signed [B_W-1:0] b,
                                             input logic signed [C_W-1:0] c);
        longint r;
        r = longint'(a) * longint'(b) + longint'(c);
        return r[P_W-1:0];
    endfunction

    always @(posedge clk) begin
        if (rst_n && ce) ce_cnt <= ce_cnt + 1;
    end

    // Scoreboard: push on handshake, pop and compare on each result pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last0 = '0;
            last1 = '0;
        end else begin
            if (bus.req0_valid && bus.req0_ready)
                q0.push_back('{val: model(bus.a0, bus.b0, bus.c0), due: ce_cnt + 3});
            if (bus.req1_valid && bus.req1_ready)
                q1.push_back('{val: model(bus.a1, bus.b1, bus.c1), due: ce_cnt + 3});
            if (bus.dout0_valid) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected0 got=%h required=no pulse", bus.dout0);
                end else begin
                    e0 = q0.pop_front();
                    if (bus.dout0 !== e0.val || ce_cnt != e0.due) begin
                        bad++;
                        $display("FAIL sb_dout0 got=%h@%0d required=%h@%0d", bus.dout0, ce_cnt, e0.val, e0.due);
                    end
                end
                last0 = bus.dout0;
            end else if (ce) begin
                total++;
                if (bus.dout0 !== last0) begin
                    bad++;
                    $display("FAIL hold0 got=%h required=%h", bus.dout0, last0);
                end
            end
            if (bus.dout1_valid) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected1 got=%h required=no pulse", bus.dout1);
                end else begin
                    e1 = q1.pop_front();
                    if (bus.dout1 !== e1.val || ce_cnt != e1.due) begin
                        bad++;
                        $display("FAIL sb_dout1 got=%h@%0d required=%h@%0d", bus.dout1, ce_cnt, e1.val, e1.due);
                    end
                end
                last1 = bus.dout1;
            end else if (ce) begin
                total++;
                if (bus.dout1 !== last1) begin
                    bad++;
                    $display("FAIL hold1 got=%h required=%h", bus.dout1, last1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.c0 = '0;
        bus.a1 = '0; bus.b1 = '0; bus.c1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ce = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [P_W-1:0] got, input logic [P_W-1:0] req);
        // Intentionally unused helper name avoided; see inline checks in each task.
    endtask

    task automatic test_reset();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b required=0", bus.req0_ready); end
        total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b required=0", bus.req1_ready); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", bus.busy); end
        total++; if (bus.dout0 !== '0) begin bad++; $display("FAIL rst_dout0 got=%h required=0", bus.dout0); end
        total++; if (bus.dout1 !== '0) begin bad++; $display("FAIL rst_dout1 got=%h required=0", bus.dout1); end
        total++; if (bus.dout0_valid !== 1'b0 || bus.dout1_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b%b required=00", bus.dout0_valid, bus.dout1_valid);
        end
        rst_n = 1'b1;
        #1;
        total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL rst_first_grant got=%b%b required=10", bus.req0_ready, bus.req1_ready);
        end
        tick();
        idle_inputs();
        repeat (5) tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.a0 = 27'sd3; bus.b0 = 18'sd4; bus.c0 = 48'sd5;
        #1;
        total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b required=1", bus.req0_ready); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 1) bus.req0_valid = 1'b0;
            total++;
            if (bus.dout0_valid !== (i == 3)) begin
                bad++; $display("FAIL single_v0 cyc=%0d got=%b required=%b", i, bus.dout0_valid, (i == 3));
            end
            if (i == 3) begin
                total++; if (bus.dout0 !== 48'd17) begin bad++; $display("FAIL single_val got=%0d required=17", bus.dout0); end
            end
            total++; if (bus.dout1_valid !== 1'b0) begin bad++; $display("FAIL single_v1 cyc=%0d got=%b required=0", i, bus.dout1_valid); end
        end
        $display("test_single done");
    endtask

    task automatic test_contention();
        do_reset();
        bus.a0 = 27'sd1; bus.b0 = 18'sd1; bus.c0 = 48'sd1;
        bus.a1 = 27'sd2; bus.b1 = 18'sd2; bus.c1 = 48'sd0;
        for (int i = 0; i <= 6; i++) begin
            bus.req0_valid = (i < 4);
            bus.req1_valid = (i < 4);
            #1;
            if (i < 4) begin
                total++;
                if (bus.req0_ready !== (i % 2 == 0) || bus.req1_ready !== (i % 2 == 1)) begin
                    bad++; $display("FAIL cont_grant cyc=%0d got=%b%b required=%b%b", i,
                                    bus.req0_ready, bus.req1_ready, (i % 2 == 0), (i % 2 == 1));
                end
            end
            total++;
            if (bus.dout0_valid !== (i == 3 || i == 5) || bus.dout1_valid !== (i == 4 || i == 6)) begin
                bad++; $display("FAIL cont_valid cyc=%0d got=%b%b required=%b%b", i, bus.dout0_valid,
                                bus.dout1_valid, (i == 3 || i == 5), (i == 4 || i == 6));
            end
            if (bus.dout0_valid) begin
                total++; if (bus.dout0 !== 48'd2) begin bad++; $display("FAIL cont_dout0 got=%0d required=2", bus.dout0); end
            end
            if (bus.dout1_valid) begin
                total++; if (bus.dout1 !== 48'd4) begin bad++; $display("FAIL cont_dout1 got=%0d required=4", bus.dout1); end
            end
            tick();
        end
        $display("test_contention done");
    endtask

    task automatic test_signed();
        do_reset();
        bus.req1_valid = 1'b1;
        bus.a1 = -27'sd7; bus.b1 = 18'sd6; bus.c1 = 48'sd2;
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1;
        bus.a0 = 27'sh3FF_FFFF; bus.b0 = 18'sh1_FFFF; bus.c0 = 48'sh7FFF_FFFF_FFFF;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        total++;
        if (bus.dout1_valid !== 1'b1 || bus.dout1 !== 48'hFFFF_FFFF_FFD8) begin
            bad++; $display("FAIL signed_neg got=%b/%h required=1/ffffffffffd8", bus.dout1_valid, bus.dout1);
        end
        tick();
        total++;
        if (bus.dout0_valid !== 1'b1 || bus.dout0 !== 48'h87FF_FBFE_0000) begin
            bad++; $display("FAIL signed_wrap got=%b/%h required=1/87fffbfe0000", bus.dout0_valid, bus.dout0);
        end
        repeat (3) tick();
        $display("test_signed done");
    endtask

    task automatic test_stall();
        int cyc;
        do_reset();
        bus.req0_valid = 1'b1;
        bus.a0 = 27'sd5; bus.b0 = -18'sd3; bus.c0 = 48'sd1;
        tick();
        ce = 1'b0;
        bus.req1_valid = 1'b1;
        bus.a0 = 27'sd100; bus.b0 = 18'sd100; bus.c0 = 48'sd100;
        for (int i = 1; i <= 2; i++) begin
            #1;
            total++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                bad++; $display("FAIL stall_ready cyc=%0d got=%b%b required=00", i, bus.req0_ready, bus.req1_ready);
            end
            total++;
            if (bus.dout0_valid !== 1'b0 || bus.busy !== 1'b1) begin
                bad++; $display("FAIL stall_state cyc=%0d got=v%b/busy%b required=v0/busy1", i, bus.dout0_valid, bus.busy);
            end
            tick();
        end
        ce = 1'b1;
        idle_inputs();
        cyc = 3;
        while (bus.dout0_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        total++; if (cyc != 5) begin bad++; $display("FAIL stall_latency got=%0d required=5", cyc); end
        total++; if (bus.dout0 !== 48'hFFFF_FFFF_FFF2) begin bad++; $display("FAIL stall_val got=%h required=fffffffffff2", bus.dout0); end
        repeat (3) tick();
        $display("test_stall done");
    endtask

    task automatic test_sampling();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.a0 = 27'sd1; bus.b0 = 18'sd1; bus.c0 = 48'sd1;
        bus.req1_valid = 1'b1;
        bus.a1 = 27'sd999; bus.b1 = 18'sd77; bus.c1 = 48'sd5555;
        tick();
        bus.req0_valid = 1'b0;
        bus.a1 = 27'sd11; bus.b1 = -18'sd5; bus.c1 = 48'sd100;
        #1;
        total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL samp_ready1 got=%b required=1", bus.req1_ready); end
        tick();
        bus.req1_valid = 1'b0;
        bus.a1 = 27'sd3000;
        tick();
        tick();
        total++;
        if (bus.dout1_valid !== 1'b1 || bus.dout1 !== 48'd45) begin
            bad++; $display("FAIL samp_dout1 got=%b/%0d required=1/45", bus.dout1_valid, bus.dout1);
        end
        repeat (3) tick();
        $display("test_sampling done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            bus.req0_valid = (i < 8);
            bus.a0 = $urandom;
            bus.b0 = $urandom;
            bus.c0 = {$urandom, $urandom};
            #1;
            if (i < 8) begin
                total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b required=1", i, bus.req0_ready); end
            end
            total++;
            if (bus.dout0_valid !== (i >= 3 && i <= 10)) begin
                bad++; $display("FAIL b2b_valid cyc=%0d got=%b required=%b", i, bus.dout0_valid, (i >= 3 && i <= 10));
            end
            total++;
            if (bus.busy !== (i >= 1 && i <= 10)) begin
                bad++; $display("FAIL b2b_busy cyc=%0d got=%b required=%b", i, bus.busy, (i >= 1 && i <= 10));
            end
            tick();
        end
        idle_inputs();
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midflight();
        do_reset();
        bus.req0_valid = 1'b1;
        bus.a0 = 27'sd9; bus.b0 = 18'sd9; bus.c0 = 48'sd9;
        tick();
        bus.a0 = 27'sd8;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.dout0 !== '0 || bus.dout1 !== '0) begin
            bad++; $display("FAIL mid_clear got=busy%b/%h/%h required=busy0/0/0", bus.busy, bus.dout0, bus.dout1);
        end
        tick();
        rst_n = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL mid_ptr got=%b%b required=10", bus.req0_ready, bus.req1_ready);
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (bus.dout0_valid !== 1'b0 || bus.dout1_valid !== 1'b0) begin
                bad++; $display("FAIL mid_pulse cyc=%0d got=%b%b required=00", i, bus.dout0_valid, bus.dout1_valid);
            end
        end
        $display("test_reset_midflight done");
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        ce_cnt = 0;
        last0  = '0;
        last1  = '0;
        rst_n  = 1'b1;
        ce     = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        tick();
        tick();
        test_reset();
        test_single();
        test_contention();
        test_signed();
        test_stall();
        test_sampling();
        test_back_to_back();
        test_reset_midflight();
        tick();
        total++;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++; $display("FAIL sb_leftover got=%0d/%0d required=0/0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_share_arbiter.md
MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- A_W, 27, signed multiplicand width.
- B_W, 18, signed multiplier width.
- C_W, 48, signed addend width.
- P_W, 48, signed result width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  global clock enable; low freezes pipeline and arbiter.
- req0_valid  in  1  requester 0 has an operand set.
- req0_ready  out  1  requester 0 operand set accepted this cycle.
- a0, b0, c0  in  A_W/B_W/C_W  requester 0 operands, signed.
- req1_valid  in  1  requester 1 has an operand set.
- req1_ready  out  1  requester 1 operand set accepted this cycle.
- a1, b1, c1  in  A_W/B_W/C_W  requester 1 operands, signed.
- dout0_valid, dout1_valid  out  1  result for requester 0/1 present this cycle.
- dout0, dout1  out  P_W  signed result a*b+c for requester 0/1.
- busy  out  1  at least one operation is in flight.

Function
REQ-003 Transfer SHALL occur when reqX_valid and reqX_ready are both high on a rising clk edge.
REQ-004 reqX_ready SHALL be combinational: high only when ce=1, rst_n=1 and requester X holds the grant.
REQ-005 At most one requester SHALL be granted per cycle. One valid requester gets the grant. Two valid requesters are resolved by round-robin.
REQ-006 The round-robin pointer SHALL use two states, PRI0 and PRI1. PRI0 grants requester 0 on a tie; PRI1 grants requester 1 on a tie.
REQ-007 After a transfer from requester X, the pointer SHALL move to the other requester. With no transfer, the pointer SHALL hold.
REQ-008 The datapath SHALL be three register stages, each advancing only when ce=1:
- S1 registers a, b, c and a 1-bit owner tag.
- S2 registers m = a*b at full A_W+B_W width, plus delayed c and tag.
- S3 registers p = sext(m) + sext(c), truncated to P_W (two's-complement wrap).
REQ-009 Latency SHALL be exactly 3 ce-enabled cycles from transfer to the matching doutX_valid pulse.
REQ-010 Each stage SHALL carry a valid bit. Bubbles SHALL propagate as valid=0.
REQ-011 doutX_valid SHALL be high for exactly one ce-enabled cycle, and only when the S3 valid bit is set and the tag equals X.
REQ-012 When a result is not valid for requester X, doutX SHALL hold its last value.
REQ-013 With ce=0, all registers, valid bits and the pointer SHALL hold; doutX_valid SHALL be forced low; no transfer SHALL occur.
REQ-014 busy SHALL be the OR of the S1, S2 and S3 valid bits.
REQ-015 Back-to-back transfers, one per cycle, SHALL be sustained with no bubbles. There is no output backpressure.
REQ-016 Operands from a requester SHALL be sampled only on its transfer cycle. Changes while not ready SHALL have no effect.

Reset
REQ-017 rst_n low SHALL asynchronously clear all valid bits, dout0 and dout1 (to 0), and busy, and set the pointer to PRI0.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight operations. No doutX_valid pulse for them SHALL appear after reset deassertion.
REQ-019 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-020 Package mac_arb_pkg SHALL hold:
- default width constants;
- LATENCY=3;
- the pointer state enum {PRI0, PRI1}.
REQ-021 The datapath SHALL be sub-module mac_pipe, containing the three stages, tag and valid bits. The arbiter SHALL contain only grant logic and the pointer.

Verification
REQ-022 Single request: req0 with a0=3, b0=4, c0=5 at cycle 0 -> dout0_valid at cycle 3 with dout0=17; dout1_valid stays 0.
REQ-023 Contention: both valid for 4 cycles from reset, with a0=b0=c0=1 and a1=2, b1=2, c1=0 -> grants 0,1,0,1; outputs 2,4,2,4 at cycles 3-6 on alternating ports.
REQ-024 Signed values: a1=-7, b1=6, c1=2 -> dout1=-40. With a0=2^26-1, b0=2^17-1, c0=2^47-1 -> result wraps modulo 2^48.
REQ-025 Stall: ce=0 for 2 cycles, starting 1 cycle after a transfer -> doutX_valid is delayed to 5 clk cycles, its value is unchanged, and no ready is asserted during the stall.
REQ-026 Reset mid-flight: transfers at cycles 0 and 1, rst_n low at cycle 2 -> busy=0, dout=0, no valid pulses afterwards, pointer is PRI0.
